// File: rtl/count_decoder.sv
// Down-counter zero detector with reload decode, sequence checking and period measurement.
// Optional feature macro: PERIOD_MEAS_EN enables the period counter and period outputs.
module count_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] count_in,
  input  logic       err_clr,
  output logic       tick,
  output logic [1:0] code_out,
  output logic       code_valid,
  output logic [4:0] period_out,
  output logic       period_valid,
  output logic       err,
  output logic       synced
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    TRACK = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] prev;
  logic       zero;
  logic       legal;
  logic [1:0] dec;
  logic       step_ok;

  assign zero    = (count_in == 4'd0);
  assign step_ok = (count_in == (prev - 4'd1));

  always_comb begin
    legal = 1'b0;
    dec   = 2'b00;
    unique case (1'b1)
      (count_in == 4'd3): begin
        legal = 1'b1;
        dec   = 2'b00;
      end
      (count_in == 4'd15): begin
        legal = 1'b1;
        dec   = 2'b01;
      end
      (count_in == 4'd10): begin
        legal = 1'b1;
        dec   = 2'b10;
      end
      default: ;
    endcase
  end

  // An error raised in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      prev       <= 4'd10;
      tick       <= 1'b0;
      code_out   <= 2'b10;
      code_valid <= 1'b0;
      err        <= 1'b0;
      synced     <= 1'b0;
    end else begin
      prev       <= count_in;
      tick       <= zero;
      code_valid <= 1'b0;
      if (err_clr)
        err <= 1'b0;
      unique case (state)
        IDLE: begin
          synced <= 1'b0;
          if (zero)
            state <= LOAD;
        end
        LOAD: begin
          if (legal) begin
            state      <= TRACK;
            synced     <= 1'b1;
            code_out   <= dec;
            code_valid <= 1'b1;
          end else if (zero) begin
            state  <= LOAD;
            synced <= 1'b0;
            err    <= 1'b1;
          end else begin
            state  <= IDLE;
            synced <= 1'b0;
            err    <= 1'b1;
          end
        end
        TRACK: begin
          if (zero) begin
            state  <= LOAD;
            synced <= 1'b0;
          end else if (!step_ok) begin
            state  <= IDLE;
            synced <= 1'b0;
            err    <= 1'b1;
          end else begin
            synced <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          synced <= 1'b0;
        end
      endcase
    end
  end

`ifdef PERIOD_MEAS_EN
  logic [4:0] pcnt;
  logic [4:0] pcnt_inc;

  assign pcnt_inc = (pcnt == 5'd31) ? 5'd31 : pcnt + 5'd1;

  // The first zero after IDLE only starts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt         <= 5'd0;
      period_out   <= 5'd0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      pcnt         <= zero ? 5'd0 : pcnt_inc;
      if (zero && (state != IDLE)) begin
        period_out   <= pcnt_inc;
        period_valid <= 1'b1;
      end
    end
  end
`else
  assign period_out   = 5'd0;
  assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_count_decoder.sv
// Directed bench for count_decoder with a reference model and literal spot checks.
module tb_count_decoder;

`ifdef PERIOD_MEAS_EN
  localparam bit PM = 1'b1;
`else
  localparam bit PM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] count_in;
  logic       err_clr;
  logic       tick;
  logic [1:0] code_out;
  logic       code_valid;
  logic [4:0] period_out;
  logic       period_valid;
  logic       err;
  logic       synced;

  int ncmp = 0;
  int nfail = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  count_decoder dut (
    .clk(clk),
    .reset(reset),
    .count_in(count_in),
    .err_clr(err_clr),
    .tick(tick),
    .code_out(code_out),
    .code_valid(code_valid),
    .period_out(period_out),
    .period_valid(period_valid),
    .err(err),
    .synced(synced)
  );

  // Reference model: tracks sync level, last sample and cycles since a zero.
  int m_tick = 0, m_code = 2, m_cv = 0, m_per = 0, m_pv = 0;
  int m_err = 0, m_sync = 0;
  int mode = 0;
  int last = 10;
  int since = 0;

  function automatic int reload_code(int r);
    case (r)
      3:  return 0;
      15: return 1;
      10: return 2;
      default: return -1;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_tick = 0; m_code = 2; m_cv = 0; m_per = 0; m_pv = 0;
      m_err = 0; m_sync = 0; mode = 0; last = 10; since = 0;
    end else begin
      int c, old_mode, e;
      c = int'(count_in);
      old_mode = mode;
      e = 0;
      m_tick = (c == 0);
      m_cv = 0;
      m_pv = 0;
      if (old_mode == 0) begin
        if (c == 0) mode = 1;
      end else if (old_mode == 1) begin
        if (reload_code(c) >= 0) begin
          m_code = reload_code(c);
          m_cv = 1;
          mode = 2;
        end else begin
          e = 1;
          mode = (c == 0) ? 1 : 0;
        end
      end else begin
        if (c == 0) mode = 1;
        else if (c != last - 1) begin
          e = 1;
          mode = 0;
        end
      end
      if (PM && c == 0 && old_mode != 0) begin
        m_per = (since + 1 > 31) ? 31 : since + 1;
        m_pv = 1;
      end
      since = (c == 0) ? 0 : ((since + 1 > 31) ? 31 : since + 1);
      if (e) m_err = 1;
      else if (err_clr) m_err = 0;
      m_sync = (mode == 2);
      last = c;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("tick", int'(tick), m_tick);
      chk("code_out", int'(code_out), m_code);
      chk("code_valid", int'(code_valid), m_cv);
      chk("period_out", int'(period_out), m_per);
      chk("period_valid", int'(period_valid), m_pv);
      chk("err", int'(err), m_err);
      chk("synced", int'(synced), m_sync);
    end
  end

  task automatic step(input logic [3:0] v, input logic c = 1'b0);
    count_in = v;
    err_clr  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tick"}, int'(tick), 0);
    chk({tag, "_code"}, int'(code_out), 2);
    chk({tag, "_cv"}, int'(code_valid), 0);
    chk({tag, "_per"}, int'(period_out), 0);
    chk({tag, "_pv"}, int'(period_valid), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_sync"}, int'(synced), 0);
  endtask

  initial begin
    reset = 1'b0;
    count_in = 4'd0;
    err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    started = 1'b1;
    count_in = 4'd10;
    #2 reset = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 9; v >= 0; v--) step(4'(v));
    chk("z1_tick", int'(tick), 1);
    chk("z1_pv", int'(period_valid), 0);
    step(4'd3);
    chk("r3_cv", int'(code_valid), 1);
    chk("r3_code", int'(code_out), 0);
    chk("r3_sync", int'(synced), 1);
    step(4'd2);
    chk("r3_cv_once", int'(code_valid), 0);
    step(4'd1);
    step(4'd0);
    chk("p4_per", int'(period_out), PM ? 4 : 0);
    chk("p4_pv", int'(period_valid), PM ? 1 : 0);
    chk("p4_tick", int'(tick), 1);
    chk("p4_err", int'(err), 0);

    for (int v = 15; v >= 1; v--) begin
      step(4'(v));
      if (v == 15) chk("r15_code", int'(code_out), 1);
    end
    step(4'd0);
    chk("p16_per", int'(period_out), PM ? 16 : 0);

    for (int v = 10; v >= 1; v--) begin
      step(4'(v));
      if (v == 10) chk("r10_code", int'(code_out), 2);
    end
    step(4'd0);
    chk("p11_per", int'(period_out), PM ? 11 : 0);

    step(4'd10); step(4'd9); step(4'd8); step(4'd7); step(4'd5);
    chk("skip_err", int'(err), 1);
    chk("skip_sync", int'(synced), 0);
    step(4'd4);
    step(4'd0);
    step(4'd3);
    chk("resync_sync", int'(synced), 1);
    chk("sticky_err", int'(err), 1);
    step(4'd2, 1'b1);
    chk("clr_err", int'(err), 0);
    step(4'd1);
    step(4'd0);
    step(4'd6);
    chk("r6_err", int'(err), 1);
    chk("r6_cv", int'(code_valid), 0);
    chk("r6_sync", int'(synced), 0);
    chk("r6_code", int'(code_out), 0);
    step(4'd5, 1'b1);
    chk("r6_clr", int'(err), 0);
    step(4'd0);
    step(4'd7, 1'b1);
    chk("err_wins", int'(err), 1);
    step(4'd0, 1'b1);
    chk("idle_clr", int'(err), 0);
    step(4'd0);
    chk("r0_err", int'(err), 1);
    chk("r0_tick", int'(tick), 1);
    chk("r0_per", int'(period_out), PM ? 1 : 0);
    step(4'd15);
    chk("r0_then15", int'(synced), 1);
    step(4'd14);
    step(4'd13);

    #3 reset = 1'b0;
    #1;
    chk_reset_vals("mid");
    @(posedge clk);
    #2 reset = 1'b1;
    step(4'd5);
    step(4'd0);
    chk("post_tick", int'(tick), 1);
    chk("post_pv", int'(period_valid), 0);
    step(4'd3);
    chk("post_code", int'(code_out), 0);
    step(4'd2);
    step(4'd1);
    @(negedge clk);
    started = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
